// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared compare-mode encodings and lane packing helper
package cpu_pkg;

  localparam int CMP_MODE_W = 3;
  localparam int MAX_W      = 64;
  localparam int MAX_CORES  = 16;
  localparam int MAX_VEC_W  = MAX_W * MAX_CORES;

  typedef enum logic [CMP_MODE_W-1:0] {
    CMP_SLT  = 3'd0,
    CMP_SLTU = 3'd1,
    CMP_SEQ  = 3'd2,
    CMP_SNE  = 3'd3,
    CMP_SGE  = 3'd4,
    CMP_SGEU = 3'd5
  } cmp_mode_e;

  // Extract lane idx of width w from a packed lane vector; caller truncates to w.
  function automatic logic [MAX_W-1:0] lane_get(input logic [MAX_VEC_W-1:0] vec,
                                                input int idx, input int w);
    logic [MAX_VEC_W-1:0] sh;
    logic [MAX_W-1:0]     m;
    sh = vec >> (idx * w);
    m  = (MAX_W'(1) << w) - MAX_W'(1);
    return sh[MAX_W-1:0] & m;
  endfunction

endpackage

// File: rtl/cmp_lane.sv
// rtl/cmp_lane.sv - single-lane combinational compare with enable and illegal-mode detect
module cmp_lane
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [CMP_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  en,
  output logic                  lane_bit,
  output logic                  lane_wen,
  output logic                  illegal
);

  logic raw;

  always_comb begin
    raw     = 1'b0;
    illegal = 1'b0;
    case (mode)
      CMP_SLT:  raw = $signed(a) < $signed(b);
      CMP_SLTU: raw = a < b;
      CMP_SEQ:  raw = a == b;
      CMP_SNE:  raw = a != b;
      CMP_SGE:  raw = $signed(a) >= $signed(b);
      CMP_SGEU: raw = a >= b;
      default:  illegal = 1'b1;
    endcase
    lane_wen = en && !illegal;
    lane_bit = lane_wen && raw;
  end

endmodule

// File: rtl/simd_compare_unit.sv
// rtl/simd_compare_unit.sv - two-stage valid/ready SIMD compare unit with lane reductions
module simd_compare_unit
  import cpu_pkg::*;
#(
  parameter int CORES = 4,
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CMP_MODE_W-1:0]    in_mode,
  input  logic [CORES-1:0]         in_mask,
  input  logic [CORES*WIDTH-1:0]   in_a,
  input  logic [CORES*WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CORES*WIDTH-1:0]   out_result,
  output logic [CORES-1:0]         out_wen,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_any,
  output logic                     out_all,
  output logic                     out_err
);

  logic                   s1_valid;
  logic [CMP_MODE_W-1:0]  s1_mode;
  logic [CORES-1:0]       s1_mask;
  logic [CORES*WIDTH-1:0] s1_a, s1_b;
  logic [TAG_W-1:0]       s1_tag;
  logic                   s2_adv;

  logic [CORES-1:0]       lane_bit, lane_wen, lane_ill;
  logic [CORES*WIDTH-1:0] result_d;
  logic                   any_d, all_d, err_d;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;

  for (genvar i = 0; i < CORES; i++) begin : g_lane
    cmp_lane #(.WIDTH(WIDTH)) u_lane (
      .mode     (s1_mode),
      .a        (WIDTH'(lane_get(MAX_VEC_W'(s1_a), i, WIDTH))),
      .b        (WIDTH'(lane_get(MAX_VEC_W'(s1_b), i, WIDTH))),
      .en       (s1_mask[i]),
      .lane_bit (lane_bit[i]),
      .lane_wen (lane_wen[i]),
      .illegal  (lane_ill[i])
    );
    assign result_d[i*WIDTH +: WIDTH] = WIDTH'(lane_bit[i]);
  end

  // Disabled lanes count as 1 for AND, but an empty enable set forces all=0.
  assign any_d = |lane_bit;
  assign all_d = (|lane_wen) && (&(lane_bit | ~lane_wen));
  assign err_d = |lane_ill;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_mode    <= '0;
      s1_mask    <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_wen    <= '0;
      out_tag    <= '0;
      out_any    <= 1'b0;
      out_all    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_mode  <= in_mode;
        s1_mask  <= in_mask;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_tag   <= in_tag;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        out_valid  <= 1'b1;
        out_result <= result_d;
        out_wen    <= lane_wen;
        out_tag    <= s1_tag;
        out_any    <= any_d;
        out_all    <= all_d;
        out_err    <= err_d;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simd_compare_unit.sv
// tb/tb_simd_compare_unit.sv - directed self-checking bench for simd_compare_unit
module tb_simd_compare_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_mode;
  logic [3:0]   in_mask;
  logic [127:0] in_a, in_b;
  logic [4:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic [3:0]   out_wen;
  logic [4:0]   out_tag;
  logic         out_any, out_all, out_err;

  int checks = 0;
  int errors = 0;

  simd_compare_unit #(.CORES(4), .WIDTH(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_mask    (in_mask),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wen    (out_wen),
    .out_tag    (out_tag),
    .out_any    (out_any),
    .out_all    (out_all),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] res(input logic [3:0] bits);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {31'b0, bits[i]};
    return r;
  endfunction

  function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic drive(input logic [2:0] m, input logic [3:0] k,
                       input logic [127:0] a, input logic [127:0] b, input logic [4:0] t);
    in_valid = 1'b1;
    in_mode  = m;
    in_mask  = k;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] va, vb, held;
  logic [31:0]  cv;
  logic         stale;

  initial begin
    va = pk(32'd3, 32'd7, 32'hFFFF_FFFF, 32'd9);
    vb = pk(32'd4, 32'd7, 32'd2, 32'd1);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_mask = '0; in_a = '0; in_b = '0; in_tag = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_result", out_result, 128'd0);
    chk("reset_flags", {out_wen, out_tag, out_any, out_all, out_err}, 128'd0);

    // Test 1: SLT latency and fields
    drive(3'd0, 4'b1111, va, vb, 5'd12);
    tick();
    in_valid = 1'b0;
    chk("slt_lat_not_yet", 128'(out_valid), 128'd0);
    tick();
    chk("slt_valid", 128'(out_valid), 128'd1);
    chk("slt_result", out_result, res(4'b0101));
    chk("slt_wen", 128'(out_wen), 128'hF);
    chk("slt_tag", 128'(out_tag), 128'd12);
    chk("slt_any_all_err", 128'({out_any, out_all, out_err}), 128'b100);

    // Test 2: SLTU, SGE, SEQ pipelined back to back
    drive(3'd1, 4'b1111, va, vb, 5'd1); tick();
    drive(3'd4, 4'b1111, va, vb, 5'd2); tick();
    chk("sltu_result", out_result, res(4'b0001));
    drive(3'd2, 4'b1111, va, vb, 5'd3); tick();
    in_valid = 1'b0;
    chk("sge_result", out_result, res(4'b1010));
    chk("sge_all", 128'({out_any, out_all}), 128'b10);
    tick();
    chk("seq_result", out_result, res(4'b0010));
    chk("seq_any", 128'(out_any), 128'd1);
    tick();
    chk("drained", 128'(out_valid), 128'd0);

    // Test 3: eight ops at full throughput
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        cv = 32'(c);
        drive(3'd2, 4'b1111, pk(cv, cv, cv, cv),
              pk(cv + 32'(c & 1), cv + 32'((c >> 1) & 1), cv + 32'((c >> 2) & 1), cv + 32'((c >> 3) & 1)),
              5'(c));
        chk("b2b_in_ready", 128'(in_ready), 128'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        chk("b2b_valid", 128'(out_valid), 128'd1);
        chk("b2b_tag", 128'(out_tag), 128'(c - 1));
        chk("b2b_result", out_result, res(~4'(c - 1)));
      end
    end
    tick();
    chk("b2b_drained", 128'(out_valid), 128'd0);

    // Test 4: backpressure
    out_ready = 1'b0;
    drive(3'd0, 4'b1111, va, vb, 5'd20);
    chk("bp_ready0", 128'(in_ready), 128'd1);
    tick();
    drive(3'd1, 4'b1111, va, vb, 5'd21);
    chk("bp_ready1", 128'(in_ready), 128'd1);
    tick();
    drive(3'd4, 4'b1111, va, vb, 5'd22);
    chk("bp_ready2", 128'(in_ready), 128'd0);
    chk("bp_head_tag", 128'(out_tag), 128'd20);
    held = out_result;
    chk("bp_head_result", held, res(4'b0101));
    tick();
    chk("bp_hold_ready", 128'(in_ready), 128'd0);
    chk("bp_hold_valid", 128'(out_valid), 128'd1);
    chk("bp_hold_tag", 128'(out_tag), 128'd20);
    chk("bp_hold_result", out_result, held);
    tick();
    chk("bp_hold2_tag", 128'(out_tag), 128'd20);
    chk("bp_hold2_result", out_result, held);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_drain21_tag", 128'(out_tag), 128'd21);
    chk("bp_drain21_res", out_result, res(4'b0001));
    tick();
    chk("bp_drain22_tag", 128'(out_tag), 128'd22);
    chk("bp_drain22_res", out_result, res(4'b1010));
    tick();
    chk("bp_drained", 128'(out_valid), 128'd0);

    // Test 5: masking and illegal modes
    drive(3'd2, 4'b0101, {4{32'd5}}, {4{32'd5}}, 5'd7); tick();
    drive(3'd2, 4'b0000, {4{32'd5}}, {4{32'd5}}, 5'd8); tick();
    chk("mask0101_result", out_result, res(4'b0101));
    chk("mask0101_wen", 128'(out_wen), 128'h5);
    chk("mask0101_any_all", 128'({out_any, out_all}), 128'b11);
    drive(3'd6, 4'b1111, va, vb, 5'd9); tick();
    in_valid = 1'b0;
    chk("mask0000_wen", 128'(out_wen), 128'h0);
    chk("mask0000_any_all", 128'({out_any, out_all}), 128'b00);
    chk("mask0000_result", out_result, 128'd0);
    tick();
    chk("illegal_valid", 128'(out_valid), 128'd1);
    chk("illegal_err", 128'(out_err), 128'd1);
    chk("illegal_wen", 128'(out_wen), 128'h0);
    chk("illegal_result", out_result, 128'd0);
    chk("illegal_tag", 128'(out_tag), 128'd9);
    tick();

    // Test 6: reset with both stages full
    out_ready = 1'b0;
    drive(3'd0, 4'b1111, va, vb, 5'd30); tick();
    drive(3'd3, 4'b1111, va, vb, 5'd31); tick();
    in_valid = 1'b0;
    chk("full_valid", 128'(out_valid), 128'd1);
    chk("full_in_ready", 128'(in_ready), 128'd0);
    reset = 1'b1;
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_outputs", {out_result[122:0], out_wen, out_tag, out_any, out_all, out_err}, 128'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_result", 128'(stale), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
